// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit combinational alu between requesters A and B.
// One operation in flight; accept -> EXEC -> RESP, with per-requester saturating completion counters.
module alu_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [DATA_W-1:0] a_op1,
  input  logic [DATA_W-1:0] a_op2,
  input  logic [2:0]        a_sel,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic              a_rsp_zero,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [DATA_W-1:0] b_op1,
  input  logic [DATA_W-1:0] b_op2,
  input  logic [2:0]        b_sel,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              b_rsp_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  a_done_cnt,
  output logic [CNT_W-1:0]  b_done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg;
  logic              last_grant_reg;  // 0 = A, 1 = B
  logic              owner_reg;       // 0 = A, 1 = B
  logic              busy_reg;
  logic [DATA_W-1:0] op1_reg;
  logic [DATA_W-1:0] op2_reg;
  logic [2:0]        sel_reg;
  logic [DATA_W-1:0] alu_res;
  logic [1:0]        rsp_ready_vec;

  assign rsp_ready_vec = {b_rsp_ready, a_rsp_ready};

  // On a tie the requester that did not win last time is served.
  assign a_req_ready = (state_reg == IDLE) & a_req_valid & (~b_req_valid | last_grant_reg);
  assign b_req_ready = (state_reg == IDLE) & b_req_valid & (~a_req_valid | ~last_grant_reg);

  assign busy = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      sel_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (a_req_ready || b_req_ready) begin
            owner_reg      <= b_req_ready;
            last_grant_reg <= b_req_ready;
            op1_reg        <= b_req_ready ? b_op1 : a_op1;
            op2_reg        <= b_req_ready ? b_op2 : a_op2;
            sel_reg        <= b_req_ready ? b_sel : a_sel;
            state_reg      <= EXEC;
            busy_reg       <= 1'b1;
          end
        end
        EXEC: begin
          state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready_vec[owner_reg]) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Shared alu, fed only from the latched operation.
  always_comb begin
    alu_res = '0;
    case (sel_reg)
      3'b000:  alu_res = op1_reg & op2_reg;
      3'b001:  alu_res = op1_reg | op2_reg;
      3'b010:  alu_res = op1_reg + op2_reg;
      3'b110:  alu_res = op1_reg - op2_reg;
      3'b111:  alu_res = DATA_W'(op1_reg < op2_reg);
      3'b100:  alu_res = ~(op1_reg | op2_reg);
      3'b101:  alu_res = op1_reg ^ op2_reg;
      default: alu_res = '0;
    endcase
  end

  // Per-requester response holding registers and completion counters.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [DATA_W-1:0] data_reg;
      logic              zero_reg;
      logic              valid_reg;
      logic [CNT_W-1:0]  cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg  <= '0;
          zero_reg  <= 1'b0;
          valid_reg <= 1'b0;
          cnt_reg   <= '0;
        end else if (state_reg == EXEC && owner_reg == 1'(gi)) begin
          data_reg  <= alu_res;
          zero_reg  <= (alu_res == '0);
          valid_reg <= 1'b1;
        end else if (valid_reg && rsp_ready_vec[gi]) begin
          valid_reg <= 1'b0;
          if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  assign a_rsp_valid = g_chan[0].valid_reg;
  assign a_rsp_data  = g_chan[0].data_reg;
  assign a_rsp_zero  = g_chan[0].zero_reg;
  assign a_done_cnt  = g_chan[0].cnt_reg;
  assign b_rsp_valid = g_chan[1].valid_reg;
  assign b_rsp_data  = g_chan[1].data_reg;
  assign b_rsp_zero  = g_chan[1].zero_reg;
  assign b_done_cnt  = g_chan[1].cnt_reg;

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one instance of the team's 32-bit combinational alu between two requesters, A and B, using round-robin arbitration. Each requester has a valid/ready request channel carrying operands and the 3-bit alu select code, plus a valid/ready response channel carrying the result and a zero flag. One operation is in flight at a time. The block also counts completed operations per requester. It sits between the issue logic and the shared alu.

Parameters:
DATA_W, 32, operand/result width; fixed at 32 to match alu.
CNT_W, 16, width of each per-requester completed-operation counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
a_req_valid  input  1  requester A presents an operation
a_req_ready  output  1  block accepts A's operation this cycle
a_op1  input  DATA_W  A operand 1
a_op2  input  DATA_W  A operand 2
a_sel  input  3  A alu select code
a_rsp_valid  output  1  A result available
a_rsp_ready  input  1  A consumes result
a_rsp_data  output  DATA_W  A result
a_rsp_zero  output  1  A result == 0
b_req_valid, b_req_ready, b_op1, b_op2, b_sel, b_rsp_valid, b_rsp_ready, b_rsp_data, b_rsp_zero: same as the A ports, for requester B
busy  output  1  operation in flight (state != IDLE)
a_done_cnt  output  CNT_W  completed A operations, saturating
b_done_cnt  output  CNT_W  completed B operations, saturating

Behaviour:
- alu select codes:
  - 000 AND, 001 OR, 010 ADD (mod 2^32), 110 SUB (mod 2^32)
  - 111 SLT, unsigned compare, result 1 or 0
  - 100 NOR, 101 XOR, 011 NOP (result 0)
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant rule:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - a_req_ready = IDLE & a_req_valid & (!b_req_valid | last_grant==B). b_req_ready is symmetric.
  - ready is combinational. At most one ready is high in any cycle.
- Transfer (valid & ready): latch op1, op2, sel and owner; set last_grant <= owner; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu is driven from the latched registers.
  - Register result into the owner's rsp_data, and (result==0) into rsp_zero.
  - Go to RESP.
- RESP:
  - The owner's rsp_valid = 1; the other requester's rsp_valid = 0.
  - rsp_data and rsp_zero are held stable until rsp_ready.
  - On the handshake: increment the owner's done_cnt, saturating at 2^CNT_W-1; go to IDLE.
- Timing:
  - Request accepted in cycle T gives rsp_valid in cycle T+2.
  - With rsp_ready high, the earliest next accept is T+3. Minimum 3 cycles per operation.
- Backpressure: while not in IDLE, both req_ready are 0, regardless of the request valids.
- A requester that drops req_valid before it is granted is simply not served; no state change results.
- Each requester's rsp_data and rsp_zero keep their last value after its handshake, until overwritten by that requester's next result.
- Reset (asynchronous, any state including mid-operation):
  - state=IDLE, last_grant=B (so A wins the first tie).
  - All rsp_data=0, rsp_zero=0, rsp_valid=0, done_cnt=0, busy=0.
  - The in-flight operation is discarded with no response.
- Undefined select codes do not exist; all 8 codes are handled.

Test Plan:
1. Reset, then A requests op1=5, op2=3, sel=010 with a_rsp_ready=1 -> a_req_ready=1 in the same cycle; a_rsp_valid at T+2 with data=8, zero=0; a_done_cnt=1; busy high T+1..T+2.
2. A and B both continuously valid for 8 operations -> grant order A,B,A,B,A,B,A,B; the other's req_ready is never high while busy; each done_cnt=4.
3. Arithmetic edges: 7 SUB 7 -> 0, zero=1. 0xFFFFFFFF ADD 1 -> 0, zero=1. 0xFFFFFFFF SLT 1 -> 0. 1 SLT 0xFFFFFFFF -> 1. NOP -> 0, zero=1. 0x0F0F NOR 0xF0F0 -> 0xFFFF0000.
4. Backpressure: B's result held with b_rsp_ready=0 for 5 cycles while A is valid -> b_rsp_valid, data and zero stable; a_req_ready=0 throughout; A is granted the cycle after the b handshake returns the FSM to IDLE.
5. rst pulsed asynchronously during EXEC -> outputs clear immediately without waiting for a clock edge; no rsp_valid appears afterwards; next tie grants A.
6. CNT_W=2, 5 A operations -> a_done_cnt sequence 1,2,3,3,3 (saturates).
